// File: rtl/ud_multiciclo_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcodes, FSM state
// encoding, datapath select codes and the decoded control word.
package ud_multiciclo_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXEC    = 4'd3,
    S_RWB     = 4'd4,
    S_ADDI_EX = 4'd5,
    S_IWB     = 4'd6,
    S_MEMADDR = 4'd7,
    S_MEMRD   = 4'd8,
    S_MEMWB   = 4'd9,
    S_MEMWR   = 4'd10,
    S_BRANCH  = 4'd11,
    S_JUMP    = 4'd12,
    S_ILLEGAL = 4'd13
  } state_t;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] SRCB_DR2     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // pc_write_fetch is the fetch-cycle PC load that the top still gates with mem_ready.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_fetch;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/ud_multiciclo_salidas.sv
// Moore output decode: maps the registered FSM state onto the datapath control word.
import ud_multiciclo_pkg::*;

module ud_multiciclo_salidas (
  input  state_t i_state,
  output ctrl_t  o_ctrl
);

  // State to control word; every field not named for a state stays 0.
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.pc_write_fetch = 1'b1;
        o_ctrl.mem_read       = 1'b1;
        o_ctrl.ir_write       = 1'b1;
        o_ctrl.alu_src_b      = SRCB_FOUR;
        o_ctrl.alu_op         = ALUOP_ADD;
        o_ctrl.pc_source      = PCSRC_ALU;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = SRCB_IMM_SH2;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_DR2;
        o_ctrl.alu_op    = ALUOP_FUNC;
      end
      S_RWB: begin
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      S_ADDI_EX, S_MEMADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_IWB: o_ctrl.reg_write = 1'b1;
      S_MEMRD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.iord      = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_DR2;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
      end
      S_ILLEGAL: o_ctrl.illegal = 1'b1;
      default:   o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/ud_multiciclo.sv
// Multicycle MIPS control unit: Moore FSM sequencing the shared datapath, plus a
// retired-instruction counter.
import ud_multiciclo_pkg::*;

module ud_multiciclo #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       Op,
  input  logic             zf,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemToWrite,
  output logic             IRWrite,
  output logic             MemToReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  state_t           r_state;
  state_t           w_next_state;
  logic             w_retire;
  logic [CNT_W-1:0] r_instr_count;
  ctrl_t            w_ctrl;
  logic             w_unused_zf;

  // The branch decision is made in the datapath through PCWriteCond.
  assign w_unused_zf = zf;

  // Next-state selection; w_retire marks the last cycle of a completed instruction.
  always_comb begin
    w_next_state = S_RESET;
    w_retire     = 1'b0;
    case (r_state)
      S_RESET:   w_next_state = S_FETCH;
      S_FETCH: begin
        if (mem_ready) w_next_state = S_DECODE;
        else           w_next_state = S_FETCH;
      end
      S_DECODE: begin
        case (Op)
          OP_R:          w_next_state = S_EXEC;
          OP_LW, OP_SW:  w_next_state = S_MEMADDR;
          OP_BEQ:        w_next_state = S_BRANCH;
          OP_J:          w_next_state = S_JUMP;
          OP_ADDI:       w_next_state = S_ADDI_EX;
          default:       w_next_state = S_ILLEGAL;
        endcase
      end
      S_EXEC:    w_next_state = S_RWB;
      S_ADDI_EX: w_next_state = S_IWB;
      S_MEMADDR: begin
        if (Op == OP_SW) w_next_state = S_MEMWR;
        else             w_next_state = S_MEMRD;
      end
      S_MEMRD: begin
        if (mem_ready) w_next_state = S_MEMWB;
        else           w_next_state = S_MEMRD;
      end
      S_MEMWR: begin
        if (mem_ready) begin
          w_next_state = S_FETCH;
          w_retire     = 1'b1;
        end else begin
          w_next_state = S_MEMWR;
        end
      end
      S_RWB, S_IWB, S_MEMWB, S_BRANCH, S_JUMP: begin
        w_next_state = S_FETCH;
        w_retire     = 1'b1;
      end
      S_ILLEGAL: w_next_state = S_ILLEGAL;
      default:   w_next_state = S_RESET;
    endcase
  end

  // State register and retired-instruction counter (wraps silently).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_RESET;
      r_instr_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_retire) r_instr_count <= r_instr_count + CNT_W'(1);
      else          r_instr_count <= r_instr_count;
    end
  end

  ud_multiciclo_salidas u_salidas (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  // Only the fetch PC load sees an input; all else follows the registered state.
  assign PCWrite     = w_ctrl.pc_write | (w_ctrl.pc_write_fetch & mem_ready);
  assign PCWriteCond = w_ctrl.pc_write_cond;
  assign IorD        = w_ctrl.iord;
  assign MemRead     = w_ctrl.mem_read;
  assign MemToWrite  = w_ctrl.mem_write;
  assign IRWrite     = w_ctrl.ir_write;
  assign MemToReg    = w_ctrl.mem_to_reg;
  assign RegDst      = w_ctrl.reg_dst;
  assign RegWrite    = w_ctrl.reg_write;
  assign ALUSrcA     = w_ctrl.alu_src_a;
  assign ALUSrcB     = w_ctrl.alu_src_b;
  assign ALUOp       = w_ctrl.alu_op;
  assign PCSource    = w_ctrl.pc_source;
  assign illegal_op  = w_ctrl.illegal;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_ud_multiciclo.sv
// Self-checking bench for ud_multiciclo: per-cycle scoreboard of expected control
// words and counts; a second 2-bit-counter instance exercises counter wrap.
module tb_ud_multiciclo;

  localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
  localparam logic [5:0] T_BEQ = 6'b000100, T_J = 6'b000010, T_ADDI = 6'b001000;
  localparam logic [5:0] T_BAD = 6'b111111;

  typedef enum int {E_RESET, E_FETCH, E_DECODE, E_EXEC, E_RWB, E_ADDI_EX, E_IWB,
                    E_MEMADDR, E_MEMRD, E_MEMWB, E_MEMWR, E_BRANCH, E_JUMP, E_ILLEGAL} es_t;

  typedef struct {
    logic [5:0]  op;
    logic        zf;
    logic        mr;
    logic        rst;
    logic [16:0] word;
    logic [31:0] cnt;
    string       tag;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, zf = 1'b0, mem_ready = 1'b0;
  logic [5:0]  Op = 6'b000000;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemToWrite, IRWrite, MemToReg;
  logic        RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [31:0] instr_count;
  logic        PCWrite_w, PCWriteCond_w, IorD_w, MemRead_w, MemToWrite_w, IRWrite_w;
  logic        MemToReg_w, RegDst_w, RegWrite_w, ALUSrcA_w, illegal_op_w;
  logic [1:0]  ALUSrcB_w, ALUOp_w, PCSource_w;
  logic [1:0]  instr_count_w;
  logic [16:0] ctl, ctl_w;

  vec_t sb[$];
  vec_t v;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  ud_multiciclo #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .zf(zf), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemToWrite(MemToWrite), .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  ud_multiciclo #(.CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .Op(Op), .zf(zf), .mem_ready(mem_ready),
    .PCWrite(PCWrite_w), .PCWriteCond(PCWriteCond_w), .IorD(IorD_w), .MemRead(MemRead_w),
    .MemToWrite(MemToWrite_w), .IRWrite(IRWrite_w), .MemToReg(MemToReg_w), .RegDst(RegDst_w),
    .RegWrite(RegWrite_w), .ALUSrcA(ALUSrcA_w), .ALUSrcB(ALUSrcB_w), .ALUOp(ALUOp_w),
    .PCSource(PCSource_w), .illegal_op(illegal_op_w), .instr_count(instr_count_w)
  );

  assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemToWrite, IRWrite, MemToReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};
  assign ctl_w = {PCWrite_w, PCWriteCond_w, IorD_w, MemRead_w, MemToWrite_w, IRWrite_w,
                  MemToReg_w, RegDst_w, RegWrite_w, ALUSrcA_w, ALUSrcB_w, ALUOp_w,
                  PCSource_w, illegal_op_w};

  // Expected control word for one cycle in state s with mem_ready = mr.
  function automatic logic [16:0] exp_word(es_t s, logic mr);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ill;
    logic [1:0] srcb, aop, psrc;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ill} = 11'b0;
    {srcb, aop, psrc} = 6'b0;
    case (s)
      E_FETCH:   begin pcw = mr; mrd = 1'b1; irw = 1'b1; srcb = 2'b01; end
      E_DECODE:  srcb = 2'b11;
      E_EXEC:    begin srca = 1'b1; aop = 2'b10; end
      E_RWB:     begin rdst = 1'b1; rw = 1'b1; end
      E_ADDI_EX, E_MEMADDR: begin srca = 1'b1; srcb = 2'b10; end
      E_IWB:     rw = 1'b1;
      E_MEMRD:   begin mrd = 1'b1; iord = 1'b1; end
      E_MEMWB:   begin m2r = 1'b1; rw = 1'b1; end
      E_MEMWR:   begin mwr = 1'b1; iord = 1'b1; end
      E_BRANCH:  begin srca = 1'b1; aop = 2'b01; pcwc = 1'b1; psrc = 2'b01; end
      E_JUMP:    begin pcw = 1'b1; psrc = 2'b10; end
      E_ILLEGAL: ill = 1'b1;
      default:   ill = 1'b0;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, psrc, ill};
  endfunction

  task automatic push(es_t s, logic [5:0] op, logic zf_v, logic mr, logic rst_v,
                      logic [31:0] cnt);
    vec_t e;
    e.op = op; e.zf = zf_v; e.mr = mr; e.rst = rst_v;
    e.word = exp_word(s, mr); e.cnt = cnt; e.tag = s.name();
    sb.push_back(e);
  endtask

  // One whole instruction with memory always ready; count shown is the pre-retire value.
  task automatic push_instr(logic [5:0] op, logic [31:0] cnt, logic zf_v);
    push(E_FETCH, op, zf_v, 1'b1, 1'b1, cnt);
    push(E_DECODE, op, zf_v, 1'b1, 1'b1, cnt);
    case (op)
      T_R:    begin push(E_EXEC, op, zf_v, 1'b1, 1'b1, cnt); push(E_RWB, op, zf_v, 1'b1, 1'b1, cnt); end
      T_ADDI: begin push(E_ADDI_EX, op, zf_v, 1'b1, 1'b1, cnt); push(E_IWB, op, zf_v, 1'b1, 1'b1, cnt); end
      T_LW: begin
        push(E_MEMADDR, op, zf_v, 1'b1, 1'b1, cnt);
        push(E_MEMRD, op, zf_v, 1'b1, 1'b1, cnt);
        push(E_MEMWB, op, zf_v, 1'b1, 1'b1, cnt);
      end
      T_SW:   begin push(E_MEMADDR, op, zf_v, 1'b1, 1'b1, cnt); push(E_MEMWR, op, zf_v, 1'b1, 1'b1, cnt); end
      T_BEQ:  push(E_BRANCH, op, zf_v, 1'b1, 1'b1, cnt);
      T_J:    push(E_JUMP, op, zf_v, 1'b1, 1'b1, cnt);
      default: push(E_ILLEGAL, op, zf_v, 1'b1, 1'b1, cnt);
    endcase
  endtask

  // Leaves the DUT in S_RESET for the cycle that follows, 1 time unit after the edge.
  task automatic do_reset();
    rst_n = 1'b0; Op = T_R; zf = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (ctl !== 17'd0) begin
      miscompares++; $display("FAIL reset_ctl got %b want %b", ctl, 17'd0);
    end
    vectors++;
    if (instr_count !== 32'd0) begin
      miscompares++; $display("FAIL reset_count got %0d want 0", instr_count);
    end
    push(E_RESET, T_J, 1'b0, 1'b1, 1'b1, 32'd0);
    push(E_FETCH, T_J, 1'b0, 1'b0, 1'b1, 32'd0);
    push(E_FETCH, T_J, 1'b0, 1'b0, 1'b1, 32'd0);
    push(E_FETCH, T_J, 1'b0, 1'b1, 1'b1, 32'd0);
    push(E_DECODE, T_J, 1'b0, 1'b1, 1'b1, 32'd0);
    while (sb.size() > 0) begin
      v = sb.pop_front(); Op = v.op; zf = v.zf; mem_ready = v.mr; rst_n = v.rst;
      @(negedge clk);
      vectors++; if (ctl !== v.word) begin miscompares++; $display("FAIL reset_seq %s ctl got %b want %b", v.tag, ctl, v.word); end
      vectors++; if (instr_count !== v.cnt) begin miscompares++; $display("FAIL reset_seq %s count got %0d want %0d", v.tag, instr_count, v.cnt); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype();
    do_reset();
    push(E_RESET, T_R, 1'b0, 1'b1, 1'b1, 32'd0);
    push_instr(T_R, 32'd0, 1'b0);
    push(E_FETCH, T_R, 1'b0, 1'b0, 1'b1, 32'd1);
    while (sb.size() > 0) begin
      v = sb.pop_front(); Op = v.op; zf = v.zf; mem_ready = v.mr; rst_n = v.rst;
      @(negedge clk);
      vectors++; if (ctl !== v.word) begin miscompares++; $display("FAIL rtype %s ctl got %b want %b", v.tag, ctl, v.word); end
      vectors++; if (instr_count !== v.cnt) begin miscompares++; $display("FAIL rtype %s count got %0d want %0d", v.tag, instr_count, v.cnt); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_wait();
    do_reset();
    push(E_RESET, T_LW, 1'b0, 1'b1, 1'b1, 32'd0);
    push(E_FETCH, T_LW, 1'b0, 1'b1, 1'b1, 32'd0);
    push(E_DECODE, T_LW, 1'b0, 1'b1, 1'b1, 32'd0);
    push(E_MEMADDR, T_LW, 1'b0, 1'b1, 1'b1, 32'd0);
    for (int i = 0; i < 3; i++) push(E_MEMRD, T_LW, 1'b0, 1'b0, 1'b1, 32'd0);
    push(E_MEMRD, T_LW, 1'b0, 1'b1, 1'b1, 32'd0);
    push(E_MEMWB, T_LW, 1'b0, 1'b1, 1'b1, 32'd0);
    push(E_FETCH, T_LW, 1'b0, 1'b0, 1'b1, 32'd1);
    while (sb.size() > 0) begin
      v = sb.pop_front(); Op = v.op; zf = v.zf; mem_ready = v.mr; rst_n = v.rst;
      @(negedge clk);
      vectors++; if (ctl !== v.word) begin miscompares++; $display("FAIL lw_wait %s ctl got %b want %b", v.tag, ctl, v.word); end
      vectors++; if (instr_count !== v.cnt) begin miscompares++; $display("FAIL lw_wait %s count got %0d want %0d", v.tag, instr_count, v.cnt); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq();
    do_reset();
    push(E_RESET, T_BEQ, 1'b1, 1'b1, 1'b1, 32'd0);
    push_instr(T_BEQ, 32'd0, 1'b1);
    push_instr(T_BEQ, 32'd1, 1'b0);
    push(E_FETCH, T_BEQ, 1'b0, 1'b0, 1'b1, 32'd2);
    while (sb.size() > 0) begin
      v = sb.pop_front(); Op = v.op; zf = v.zf; mem_ready = v.mr; rst_n = v.rst;
      @(negedge clk);
      vectors++; if (ctl !== v.word) begin miscompares++; $display("FAIL beq %s ctl got %b want %b", v.tag, ctl, v.word); end
      vectors++; if (instr_count !== v.cnt) begin miscompares++; $display("FAIL beq %s count got %0d want %0d", v.tag, instr_count, v.cnt); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    do_reset();
    push(E_RESET, T_R, 1'b0, 1'b1, 1'b1, 32'd0);
    push_instr(T_R, 32'd0, 1'b0);
    push(E_FETCH, T_BAD, 1'b0, 1'b1, 1'b1, 32'd1);
    push(E_DECODE, T_BAD, 1'b0, 1'b1, 1'b1, 32'd1);
    for (int i = 0; i < 20; i++)
      push(E_ILLEGAL, (i % 3 == 0) ? T_R : T_BAD, i[0], i[1], 1'b1, 32'd1);
    while (sb.size() > 0) begin
      v = sb.pop_front(); Op = v.op; zf = v.zf; mem_ready = v.mr; rst_n = v.rst;
      @(negedge clk);
      vectors++; if (ctl !== v.word) begin miscompares++; $display("FAIL illegal %s ctl got %b want %b", v.tag, ctl, v.word); end
      vectors++; if (instr_count !== v.cnt) begin miscompares++; $display("FAIL illegal %s count got %0d want %0d", v.tag, instr_count, v.cnt); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    push(E_RESET, T_R, 1'b0, 1'b1, 1'b1, 32'd0);
    push_instr(T_R, 32'd0, 1'b0);
    push(E_FETCH, T_SW, 1'b0, 1'b1, 1'b1, 32'd1);
    push(E_DECODE, T_SW, 1'b0, 1'b1, 1'b1, 32'd1);
    push(E_MEMADDR, T_SW, 1'b0, 1'b1, 1'b1, 32'd1);
    push(E_MEMWR, T_SW, 1'b0, 1'b0, 1'b1, 32'd1);
    push(E_MEMWR, T_SW, 1'b0, 1'b1, 1'b0, 32'd1);
    push(E_RESET, T_SW, 1'b0, 1'b1, 1'b1, 32'd0);
    push(E_FETCH, T_SW, 1'b0, 1'b0, 1'b1, 32'd0);
    while (sb.size() > 0) begin
      v = sb.pop_front(); Op = v.op; zf = v.zf; mem_ready = v.mr; rst_n = v.rst;
      @(negedge clk);
      vectors++; if (ctl !== v.word) begin miscompares++; $display("FAIL midreset %s ctl got %b want %b", v.tag, ctl, v.word); end
      vectors++; if (instr_count !== v.cnt) begin miscompares++; $display("FAIL midreset %s count got %0d want %0d", v.tag, instr_count, v.cnt); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wrap();
    do_reset();
    push(E_RESET, T_J, 1'b0, 1'b1, 1'b1, 32'd0);
    for (int i = 0; i < 5; i++) push_instr(T_J, i, 1'b0);
    push(E_FETCH, T_J, 1'b0, 1'b0, 1'b1, 32'd5);
    while (sb.size() > 0) begin
      v = sb.pop_front(); Op = v.op; zf = v.zf; mem_ready = v.mr; rst_n = v.rst;
      @(negedge clk);
      vectors++; if (ctl !== v.word) begin miscompares++; $display("FAIL wrap %s ctl got %b want %b", v.tag, ctl, v.word); end
      vectors++; if (instr_count !== v.cnt) begin miscompares++; $display("FAIL wrap %s count got %0d want %0d", v.tag, instr_count, v.cnt); end
      vectors++; if (ctl_w !== v.word) begin miscompares++; $display("FAIL wrap2 %s ctl got %b want %b", v.tag, ctl_w, v.word); end
      vectors++; if (instr_count_w !== v.cnt[1:0]) begin miscompares++; $display("FAIL wrap2 %s count got %0d want %0d", v.tag, instr_count_w, v.cnt[1:0]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push(E_RESET, T_ADDI, 1'b0, 1'b1, 1'b1, 32'd0);
    push_instr(T_ADDI, 32'd0, 1'b0);
    push(E_FETCH, T_SW, 1'b0, 1'b0, 1'b1, 32'd1);
    push_instr(T_SW, 32'd1, 1'b0);
    push_instr(T_LW, 32'd2, 1'b0);
    push_instr(T_BEQ, 32'd3, 1'b0);
    push_instr(T_R, 32'd4, 1'b1);
    push(E_FETCH, T_R, 1'b0, 1'b0, 1'b1, 32'd5);
    while (sb.size() > 0) begin
      v = sb.pop_front(); Op = v.op; zf = v.zf; mem_ready = v.mr; rst_n = v.rst;
      @(negedge clk);
      vectors++; if (ctl !== v.word) begin miscompares++; $display("FAIL b2b %s ctl got %b want %b", v.tag, ctl, v.word); end
      vectors++; if (instr_count !== v.cnt) begin miscompares++; $display("FAIL b2b %s count got %0d want %0d", v.tag, instr_count, v.cnt); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_reset_midflight();
    test_wrap();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d vectors", vectors);
    $fatal(1, "watchdog");
  end

endmodule
